// File: rtl/pwm_timer_core.sv
// PWM / timer output stage fed by main_counter: generates the registered PWM
// pad output, the period-match event, the sticky irq flag and one-shot status.
module pwm_timer_core #(
    parameter int CW = 16
) (
    input  logic          slow_clk,
    input  logic          rst_n,
    input  logic          sw_rst,
    input  logic          core_en,
    input  logic          mode,
    input  logic          timer_mode,
    input  logic          out_en,
    input  logic          irq_en,
    input  logic          irq_clr,
    input  logic [CW-1:0] period_reg,
    input  logic [CW-1:0] duty_reg,
    input  logic [CW-1:0] counter,
    output logic          o_pwm,
    output logic          irq_flag,
    output logic          o_irq,
    output logic          timer_done
);

    logic [CW-1:0] duty_sh;
    logic [CW-1:0] period_m1;
    logic          period_ok;
    logic          at_wrap;
    logic          match;
    logic          match_d;
    logic          evt;
    logic          pwm_next;

    assign period_m1 = period_reg - CW'(1);
    assign period_ok = |period_reg;
    assign at_wrap   = period_ok && (counter == period_m1);

    // PWM counts 0..period-1, timer counts 0..period, so the match point differs
    assign match = core_en && period_ok &&
                   (mode ? (counter == period_m1) : (counter == period_reg));
    assign evt   = match && !match_d;

    assign pwm_next = core_en && mode && out_en && period_ok && (counter < duty_sh);
    assign o_irq    = irq_flag & irq_en;

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pwm      <= 1'b0;
            irq_flag   <= 1'b0;
            timer_done <= 1'b0;
            match_d    <= 1'b0;
            duty_sh    <= '0;
        end else if (sw_rst) begin
            o_pwm      <= 1'b0;
            irq_flag   <= 1'b0;
            timer_done <= 1'b0;
            match_d    <= 1'b0;
            duty_sh    <= '0;
        end else begin
            match_d <= match;
            o_pwm   <= pwm_next;

            // shadow only at period end so mid-period writes never glitch the pad
            if (!core_en || (mode && at_wrap))
                duty_sh <= duty_reg;

            if (evt && !timer_done)
                irq_flag <= 1'b1;
            else if (irq_clr)
                irq_flag <= 1'b0;

            if (!core_en)
                timer_done <= 1'b0;
            else if (evt && !mode && !timer_mode)
                timer_done <= 1'b1;
        end
    end

endmodule

// File: doc/pwm_timer_core.md
# pwm_timer_core

Output stage that consumes the 16-bit `main_counter` value and turns it into the PWM waveform, the timer period-match event and the interrupt. Sits in the `slow_clk` domain, directly downstream of `main_counter`. Inputs come from the register file (ctrl bits, period, duty) and from the counter. Outputs drive the PWM pad, the interrupt line and the status register.

## Interface
- `CW`, 16: counter, period and duty width.
- `slow_clk`  in  1: slow clock from the clock divider. All state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sw_rst`  in  1: synchronous software reset, active-high level.
- `core_en`  in  1: ctrl[2]. The same enable that drives `main_counter`.
- `mode`  in  1: ctrl[1]. 1 = PWM, 0 = timer.
- `timer_mode`  in  1: ctrl[3]. 1 = continuous, 0 = one-shot.
- `out_en`  in  1: PWM pad enable.
- `irq_en`  in  1: interrupt mask. 1 = interrupt passes to `o_irq`.
- `irq_clr`  in  1: one-cycle pulse that clears `irq_flag`.
- `period_reg`  in  CW: period register.
- `duty_reg`  in  CW: duty register (raw, unshadowed).
- `counter`  in  CW: output of `main_counter`.
- `o_pwm`  out  1: registered PWM output.
- `irq_flag`  out  1: sticky event flag, mirrored in the status register.
- `o_irq`  out  1: `irq_flag & irq_en`. Combinational from registers.
- `timer_done`  out  1: one-shot completion status.

## Operation
- Counter sequences the block expects:
  - PWM: 0..period_reg-1, then wrap.
  - Timer continuous: 0..period_reg, then wrap.
  - Timer one-shot: 0..period_reg once, then held at 0.
  - Counter holds its value while `core_en`=0.
- Duty shadow `duty_sh` (CW bits) is loaded from `duty_reg`:
  - every cycle while `core_en`=0, and
  - in PWM mode, on the cycle `counter == period_reg-1`, so a new duty takes effect from the next period's count 0.
  - At all other times `duty_sh` is unchanged; mid-period writes to `duty_reg` never glitch the output.
- PWM output:
  - Next `o_pwm` = `core_en & mode & out_en & (counter < duty_sh)`. Compare is unsigned.
  - `duty_sh` = 0 gives constant low.
  - `duty_sh >= period_reg` gives constant high.
  - `period_reg` = 0 gives constant low.
- Match condition `match`:
  - PWM mode: `counter == period_reg-1`.
  - Timer mode: `counter == period_reg`.
  - Qualified by `core_en=1` and `period_reg != 0`. With `period_reg` = 0 no event is ever generated.
- Event = `match & ~match_d`, where `match_d` is `match` registered. This is rising-edge detection, so a held counter cannot re-trigger.
- `irq_flag`:
  - Set by an event.
  - Cleared by `irq_clr`.
  - Simultaneous set and clear: set wins.
- `timer_done`:
  - Set by the first event in timer mode with `timer_mode`=0.
  - Holds until `core_en` falls, `sw_rst`, or `rst_n`.
  - While `timer_done`=1, further events do not set `irq_flag`.
- Mode or `timer_mode` changes while enabled: no special handling. Software must disable before reconfiguring.

## Timing
- Reset values under `rst_n`=0 (async) or `sw_rst`=1 (next edge):
  - `o_pwm`, `irq_flag`, `timer_done`, `match_d` = 0.
  - `o_irq` = 0.
  - `duty_sh` = 0.
- Priority: `rst_n` > `sw_rst` > all functional updates.
- Latency: one `slow_clk` from a `counter` value to the corresponding `o_pwm`, `irq_flag` or `timer_done` update.
- `o_irq` follows `irq_flag` and `irq_en` with no added cycle.
- `irq_clr` takes effect at the edge where it is sampled high; the flag reads 0 from the following cycle.
- Duty update at period end: the first `o_pwm` using the new duty appears one cycle after `counter` wraps to 0.
- `core_en` falling: `o_pwm` goes 0 on the next edge. `irq_flag` keeps its value; `timer_done` clears.

## Test plan
- Reset mid-activity:
  - Stimulus: drive `rst_n`=0 while `o_pwm`=1 and `irq_flag`=1.
  - Response: `o_pwm`, `irq_flag`, `o_irq`, `timer_done` = 0 immediately, before any clock edge; `sw_rst`=1 does the same at the next edge.
- PWM duty:
  - Stimulus: `mode`=1, `period_reg`=4, `duty_reg`=1 loaded while disabled, then `core_en`=1, `out_en`=1, counter 0,1,2,3,0,...
  - Response: `o_pwm` sequence 1,0,0,0 repeating, lagging the counter by one cycle. `irq_flag` sets one cycle after counter=3.
- Duty change mid-period:
  - Stimulus: with `period_reg`=4, write `duty_reg`=3 at counter=1.
  - Response: the current period still shows 1 high cycle; the next period shows 3 high, 1 low. Also, `duty_reg`=5 gives constant high and `duty_reg`=0 gives constant low.
- Timer continuous:
  - Stimulus: `mode`=0, `timer_mode`=1, `period_reg`=4, `irq_en`=1.
  - Response: `o_irq` rises one cycle after counter=4 in each period.
  - `irq_clr` pulsed after the first event: `irq_flag` drops, then re-sets at the next counter=4.
  - `irq_clr` pulsed on the same edge as an event: `irq_flag` stays 1.
- Timer one-shot:
  - Stimulus: `timer_mode`=0, `period_reg`=4; counter runs 0..4 then holds 0 for 5 cycles.
  - Response: `timer_done` and `irq_flag` set once, one cycle after counter=4, and remain set.
  - Dropping `core_en` clears `timer_done` and leaves `irq_flag`=1.
- Disable and zero period:
  - Stimulus 1: `core_en`=0 with counter held at 3 for 5 cycles. Response: `o_pwm`=0 and no events.
  - Stimulus 2: `period_reg`=0 in either mode. Response: `o_pwm`=0 and `irq_flag` never sets.
